// File: rtl/led_flick_pkg.sv
// Shared types for the LED flicker bar: FSM state encoding and its width.
package led_flick_pkg;
    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FILL1  = 3'd1,
        ST_DRAIN1 = 3'd2,
        ST_FILL2  = 3'd3,
        ST_DRAIN2 = 3'd4
    } state_e;
endpackage

// File: rtl/flick_sync_edge.sv
// Two-flop synchronizer for the push-button level plus a rising-edge detector
// producing a single-clock pulse.
module flick_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic flick_in,
    output logic pulse_out
);
    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= flick_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Held-high-through-reset presses still produce one edge because the
    // flops come out of reset at 0.
    assign pulse_out = s2_q & ~prev_q;
endmodule

// File: rtl/led_flick_gen.sv
// Thermometer LED bar that fills, drains to B1, refills to B2 and drains out;
// a press near the B1 breakpoint or at empty kicks the bar back up.
module led_flick_gen
    import led_flick_pkg::*;
#(
    parameter int N_LED = 16,
    parameter int B1    = 5,
    parameter int B2    = 10,
    parameter int DIV   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flick,
    output logic [N_LED-1:0]             LED,
    output logic [ST_W-1:0]              current_state,
    output logic [$clog2(N_LED+1)-1:0]   current_index,
    output logic                         busy
);
    localparam int CW = $clog2(N_LED + 1);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] IDX_FULL = CW'(N_LED);
    localparam logic [CW-1:0] IDX_B1   = CW'(B1);
    localparam logic [CW-1:0] IDX_B2   = CW'(B2);
    localparam logic [PW-1:0] PS_LAST  = PW'(DIV - 1);

    if (!(B1 > 0 && B1 < B2 && B2 < N_LED && DIV >= 1)) begin : g_param_chk
        $error("led_flick_gen: parameters need 0 < B1 < B2 < N_LED and DIV >= 1");
    end

    logic          pulse;
    logic          tick;
    logic [PW-1:0] ps_q, ps_d;
    logic          pend_q, pend_d;
    state_e        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;

    flick_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .flick_in (flick),
        .pulse_out(pulse)
    );

    assign tick = (ps_q == PS_LAST);
    assign ps_d = tick ? '0 : ps_q + PW'(1);

    // A tick always consumes the flag; a pulse landing on that same tick is
    // kept for the following one.
    assign pend_d = tick ? pulse : (pend_q | pulse);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q    <= '0;
            pend_q  <= 1'b0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            ps_q    <= ps_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // On reaching a phase target the next phase's first step is taken on the
    // same tick, so the index never dwells at a breakpoint.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (tick && pend_q) begin
                    state_d = ST_FILL1;
                    idx_d   = CW'(1);
                end
            end
            ST_FILL1: if (tick) begin
                if (idx_q == IDX_FULL) begin
                    state_d = ST_DRAIN1;
                    idx_d   = idx_q - CW'(1);
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            ST_DRAIN1: if (tick) begin
                if (idx_q == IDX_B1) begin
                    state_d = pend_q ? ST_FILL1 : ST_FILL2;
                    idx_d   = idx_q + CW'(1);
                end else begin
                    idx_d = idx_q - CW'(1);
                end
            end
            ST_FILL2: if (tick) begin
                if (idx_q == IDX_B2) begin
                    state_d = ST_DRAIN2;
                    idx_d   = idx_q - CW'(1);
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            ST_DRAIN2: if (tick) begin
                if (idx_q == '0) begin
                    state_d = pend_q ? ST_FILL1 : ST_IDLE;
                    idx_d   = pend_q ? CW'(1) : '0;
                end else if (idx_q == IDX_B1 && pend_q) begin
                    state_d = ST_FILL2;
                    idx_d   = idx_q + CW'(1);
                end else begin
                    idx_d = idx_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        LED = '0;
        for (int i = 0; i < N_LED; i++) begin
            LED[i] = (CW'(i) < idx_q);
        end
    end

    assign current_state = state_q;
    assign current_index = idx_q;
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_led_flick_gen.sv
// Directed bench for led_flick_gen: default bar at DIV=1 plus a small 8-LED,
// DIV=4 instance for prescaler behaviour.
module tb_led_flick_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flick = 1'b0;
    logic        flick8 = 1'b0;
    logic [15:0] led;
    logic [2:0]  st;
    logic [4:0]  idx;
    logic        busy;
    logic [7:0]  led8;
    logic [2:0]  st8;
    logic [3:0]  idx8;
    logic        busy8;

    int n_chk = 0;
    int n_fail = 0;
    int t = 0;

    always #5 clk = ~clk;

    led_flick_gen dut (
        .clk(clk), .reset(rst_n), .flick(flick),
        .LED(led), .current_state(st), .current_index(idx), .busy(busy)
    );

    led_flick_gen #(.N_LED(8), .B1(2), .B2(5), .DIV(4)) dut8 (
        .clk(clk), .reset(rst_n), .flick(flick8),
        .LED(led8), .current_state(st8), .current_index(idx8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Tick k of a run is visible at the negedge after the (3+k)-th posedge
    // following the negedge where flick rose; that negedge is t=-3.
    task automatic go(input int k);
        repeat (k - t) @(negedge clk);
        t = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_seq();
        flick = 1'b1;
        t = -3;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full unkicked cycle with latency check.
        start_seq();
        go(-1); flick = 1'b0;
        go(0);  chk("lat_led0", 32'(led), 32'h0);
                chk("lat_busy0", 32'(busy), 32'd0);
        go(1);  chk("lat_led1", 32'(led), 32'h0001);
                chk("lat_st1", 32'(st), 32'd1);
        go(16); chk("full_led", 32'(led), 32'hFFFF);
        go(17); chk("d1_st", 32'(st), 32'd2);
                chk("d1_idx", 32'(idx), 32'd15);
        go(27); chk("b1_led", 32'(led), 32'h001F);
        go(28); chk("f2_st", 32'(st), 32'd3);
                chk("f2_idx", 32'(idx), 32'd6);
        go(32); chk("b2_led", 32'(led), 32'h03FF);
        go(33); chk("d2_st", 32'(st), 32'd4);
                chk("d2_idx", 32'(idx), 32'd9);
        go(42); chk("empty_led", 32'(led), 32'h0000);
                chk("empty_busy", 32'(busy), 32'd1);
        go(43); chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_st", 32'(st), 32'd0);
        go(50); chk("stay_idle", 32'(st), 32'd0);

        // DRAIN1 kickback at B1.
        do_reset();
        start_seq();
        go(-1); flick = 1'b0;
        go(24); flick = 1'b1;
        go(26); flick = 1'b0;
        go(27); chk("kb1_pre_idx", 32'(idx), 32'd5);
                chk("kb1_pre_st", 32'(st), 32'd2);
        go(28); chk("kb1_st", 32'(st), 32'd1);
                chk("kb1_idx", 32'(idx), 32'd6);
        go(38); chk("kb1_full", 32'(led), 32'hFFFF);

        // DRAIN2 kickback at B1.
        do_reset();
        start_seq();
        go(-1); flick = 1'b0;
        go(34); flick = 1'b1;
        go(36); flick = 1'b0;
        go(37); chk("kb2_pre_idx", 32'(idx), 32'd5);
                chk("kb2_pre_st", 32'(st), 32'd4);
        go(38); chk("kb2_st", 32'(st), 32'd3);
                chk("kb2_idx", 32'(idx), 32'd6);

        // DRAIN2 restart at empty.
        do_reset();
        start_seq();
        go(-1); flick = 1'b0;
        go(39); flick = 1'b1;
        go(41); flick = 1'b0;
        go(42); chk("kb0_pre_idx", 32'(idx), 32'd0);
                chk("kb0_pre_st", 32'(st), 32'd4);
        go(43); chk("kb0_st", 32'(st), 32'd1);
                chk("kb0_led", 32'(led), 32'h0001);

        // Press during FILL1 is discarded; timing unchanged.
        do_reset();
        start_seq();
        go(-1); flick = 1'b0;
        go(5);  flick = 1'b1;
        go(7);  flick = 1'b0;
        go(9);  chk("ign_idx", 32'(idx), 32'd9);
        go(16); chk("ign_full", 32'(led), 32'hFFFF);
        go(27); chk("ign_b1", 32'(led), 32'h001F);
        go(32); chk("ign_b2", 32'(led), 32'h03FF);
        go(42); chk("ign_empty", 32'(led), 32'h0000);
        go(43); chk("ign_idle", 32'(busy), 32'd0);

        // Reset mid-DRAIN1 aborts; presses during reset are ignored.
        do_reset();
        start_seq();
        go(-1); flick = 1'b0;
        go(20); chk("ab_pre_idx", 32'(idx), 32'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_led", 32'(led), 32'h0);
        chk("ab_st", 32'(st), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        repeat (4) begin
            @(negedge clk);
            flick = ~flick;
        end
        flick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("ab_post_st", 32'(st), 32'd0);
        chk("ab_post_idx", 32'(idx), 32'd0);

        // Flick held across reset release counts as one press.
        @(negedge clk);
        rst_n = 1'b0;
        flick = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = -3;
        go(0);  chk("hold_idx0", 32'(idx), 32'd0);
        go(1);  chk("hold_idx1", 32'(idx), 32'd1);
                chk("hold_st1", 32'(st), 32'd1);
        go(43); chk("hold_idle", 32'(st), 32'd0);
        go(50); chk("hold_once", 32'(busy), 32'd0);
        flick = 1'b0;

        // DIV=4 instance: tick on every 4th edge after release, a pulse that
        // coincides with a tick only acts on the next one.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        go(1);  flick8 = 1'b1;
        go(4);  flick8 = 1'b0;
        go(7);  chk("d4_idx_e7", 32'(idx8), 32'd0);
        go(8);  chk("d4_idx_e8", 32'(idx8), 32'd1);
                chk("d4_st_e8", 32'(st8), 32'd1);
        go(11); chk("d4_idx_e11", 32'(idx8), 32'd1);
        go(12); chk("d4_idx_e12", 32'(idx8), 32'd2);
        go(35); chk("d4_idx_e35", 32'(idx8), 32'd7);
        go(36); chk("d4_full", 32'(led8), 32'hFF);
        go(40); chk("d4_d1_st", 32'(st8), 32'd2);
                chk("d4_d1_idx", 32'(idx8), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/led_flick_gen.md
LED_FLICK_GEN -- requirements
Module: led_flick_gen

Interface
REQ-001 Parameter N_LED, default 16: number of LEDs in the thermometer bar.
REQ-002 Parameter B1, default 5: low breakpoint (lit count).
REQ-003 Parameter B2, default 10: high breakpoint (lit count).
REQ-004 Parameter DIV, default 1: clocks per step tick; DIV=1 means a tick every clock.
REQ-005 CW = $clog2(N_LED+1) SHALL be derived locally, not overridable.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 flick  in  1  asynchronous push-button level.
REQ-009 LED  out  N_LED  thermometer output; LED[i]=1 iff i < current_index.
REQ-010 current_state  out  3  FSM state encoding.
REQ-011 current_index  out  CW  lit count, range 0..N_LED.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 flick SHALL pass a 2-flop synchronizer, then a rising-edge detect that yields a 1-clock pulse.
REQ-014 A pulse SHALL set a pending flag; the flag SHALL clear on the next tick whether or not it is used.
REQ-015 Prescaler: counter 0..DIV-1, free-running in all states; tick is asserted when counter==DIV-1.
REQ-016 States: IDLE=0, FILL1=1, DRAIN1=2, FILL2=3, DRAIN2=4; encodings 5-7 SHALL recover to IDLE on the next clock.
REQ-017 Steps occur only on ticks; FILL steps are +1 and DRAIN steps are -1.
REQ-018 Phase targets: FILL1=N_LED, DRAIN1=B1, FILL2=B2, DRAIN2=0.
REQ-019 On a tick where current_index equals the phase target, the state SHALL advance and the new phase's first step SHALL apply on that same tick.
REQ-020 IDLE: index held at 0; on a tick with pending set -> FILL1, index=1.
REQ-021 FILL1 at N_LED -> DRAIN1.
REQ-022 DRAIN1 at B1 -> FILL2.
REQ-023 DRAIN1 kickback: at B1 with pending set -> FILL1 instead of FILL2 (step to B1+1).
REQ-024 FILL2 at B2 -> DRAIN2.
REQ-025 DRAIN2 at B1 with pending set -> FILL2 (step to B1+1); without pending, DRAIN2 continues down.
REQ-026 DRAIN2 at 0 with pending set -> FILL1, index=1; without pending -> IDLE, index stays 0.
REQ-027 A pulse arriving in any other state or index is discarded at the next tick.
REQ-028 Latency, DIV=1: LED[0] rises on the 4th rising clk edge after flick is first sampled high.
REQ-029 Full unkicked cycle, DIV=1, defaults: index 16 at tick 16, 5 at tick 27, 10 at tick 32, 0 at tick 42, IDLE at tick 43.
REQ-030 A pulse coincident with a tick is registered and takes effect on the following tick.
REQ-031 Elaboration SHALL fail unless 0<B1<B2<N_LED and DIV>=1.

Reset
REQ-032 On reset low, asynchronously: state=IDLE, index=0, LED=0, busy=0, prescaler=0, pending=0, synchronizer flops=0.
REQ-033 Reset asserted mid-sequence SHALL abort it immediately; no resume after release.
REQ-034 Pulses during reset SHALL be ignored.
REQ-035 A flick held high across reset deassertion SHALL count as exactly one press.

Structure
REQ-036 Shared package led_flick_pkg SHALL hold the state enum and its 3-bit width constant.
REQ-037 Sub-module flick_sync_edge SHALL contain the synchronizer and edge detector; it has ports clk, reset, flick_in and pulse_out.
REQ-038 The prescaler, pending flag and FSM/index datapath SHALL reside in led_flick_gen.

Verification
REQ-039 Defaults, DIV=1, one 2-clk flick pulse, no further presses -> LED 0x0001, 0xFFFF at tick 16, 0x001F at tick 27, 0x03FF at tick 32, 0x0000 at tick 42, busy=0 at tick 43.
REQ-040 Flick timed so pending is set on the tick where DRAIN1 index=5 -> state FILL1, index 6, then refill to 0xFFFF.
REQ-041 Flick on the tick where DRAIN2 index=5 -> FILL2, index 6. Flick on the tick where DRAIN2 index=0 -> FILL1, index 1.
REQ-042 Flick during FILL1 at index 8 -> no effect; the sequence timing is unchanged versus REQ-039.
REQ-043 Reset low at DRAIN1 index=12, with flick toggled during reset -> LED=0 and IDLE immediately; after release, no activity until a new flick.
REQ-044 N_LED=8, B1=2, B2=5, DIV=4 -> exactly one step per 4 clocks; LED reaches 0xFF after 32 clocks of FILL1; index width is 4.
